uv_spi_apb_arb: RTL and testbench



---
 rtl/uv_spi_apb_arb.sv | 172 +++++++++++++++++
 tb/tb_uv_spi_apb_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uv_spi_apb_arb.sv
// Shares one SPI controller APB register port between CPU (port 0) and DMA (port 1), round-robin with ownership hold.
// Latency: request seen in IDLE -> SETUP next cycle -> ACCESS the cycle after; completes on spi_pready or watchdog timeout.
// Backpressure: the losing port's request simply waits (pready held low); one transfer in flight, one IDLE cycle between transfers.
module uv_spi_apb_arb #(
    parameter int ALEN     = 12,
    parameter int DLEN     = 32,
    parameter int MLEN     = DLEN / 8,
    parameter int HOLD_MAX = 4,
    parameter int TMO_CYC  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    // upstream port 0 (CPU)
    input  logic            m0_psel,
    input  logic            m0_penable,
    input  logic            m0_pwrite,
    input  logic [2:0]      m0_pprot,
    input  logic [ALEN-1:0] m0_paddr,
    input  logic [MLEN-1:0] m0_pstrb,
    input  logic [DLEN-1:0] m0_pwdata,
    output logic [DLEN-1:0] m0_prdata,
    output logic            m0_pready,
    output logic            m0_pslverr,
    // upstream port 1 (DMA / flash loader)
    input  logic            m1_psel,
    input  logic            m1_penable,
    input  logic            m1_pwrite,
    input  logic [2:0]      m1_pprot,
    input  logic [ALEN-1:0] m1_paddr,
    input  logic [MLEN-1:0] m1_pstrb,
    input  logic [DLEN-1:0] m1_pwdata,
    output logic [DLEN-1:0] m1_prdata,
    output logic            m1_pready,
    output logic            m1_pslverr,
    // downstream toward the SPI controller
    output logic            spi_psel,
    output logic            spi_penable,
    output logic            spi_pwrite,
    output logic [2:0]      spi_pprot,
    output logic [ALEN-1:0] spi_paddr,
    output logic [MLEN-1:0] spi_pstrb,
    output logic [DLEN-1:0] spi_pwdata,
    input  logic [DLEN-1:0] spi_prdata,
    input  logic            spi_pready,
    input  logic            spi_pslverr,
    // status
    output logic            arb_owner,
    output logic            arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_own;
    logic [3:0]  r_hold_cnt;
    logic [15:0] r_tmo_cnt;

    logic        w_grant;
    logic        w_keep;
    logic        w_start;
    logic        w_tmo;
    logic        w_done;
    logic        w_err;
    logic [DLEN-1:0] w_rdata;

    // Request-phase penable is not needed: a request is psel alone.
    logic        w_unused;
    assign w_unused = m0_penable ^ m1_penable;

    // Owner may keep the port only if it has actually been granted since reset
    // (hold_cnt of 0 means nobody owns it yet, so the other port goes first).
    assign w_keep = (r_hold_cnt != 4'd0) && (r_hold_cnt < 4'(HOLD_MAX));

    assign w_tmo  = (r_state == ST_ACCESS) && !spi_pready &&
                    (r_tmo_cnt == 16'(TMO_CYC - 1));
    assign w_done = (r_state == ST_ACCESS) && (spi_pready || w_tmo);
    assign w_start = (r_state == ST_IDLE) && (w_state_nxt == ST_SETUP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decision (grant only meaningful in IDLE)
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = r_own;
        case (r_state)
            ST_IDLE: begin
                if (m0_psel || m1_psel) begin
                    w_state_nxt = ST_SETUP;
                    if (m0_psel && m1_psel) begin
                        w_grant = w_keep ? r_own : ~r_own;
                    end else begin
                        w_grant = m1_psel;
                    end
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (spi_pready || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner and track how many consecutive grants it has had
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own      <= 1'b0;
            r_hold_cnt <= 4'd0;
        end else if (w_start) begin
            r_own <= w_grant;
            if (w_grant != r_own) begin
                r_hold_cnt <= 4'd1;
            end else if (r_hold_cnt != 4'd15) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end
    end

    // Watchdog: counts ACCESS cycles without pready, restarted in SETUP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == ST_ACCESS) && !spi_pready) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // Downstream: phase from state, payload from the owning port
    assign spi_psel    = (r_state != ST_IDLE);
    assign spi_penable = (r_state == ST_ACCESS);
    assign spi_pwrite  = r_own ? m1_pwrite : m0_pwrite;
    assign spi_pprot   = r_own ? m1_pprot  : m0_pprot;
    assign spi_paddr   = r_own ? m1_paddr  : m0_paddr;
    assign spi_pstrb   = r_own ? m1_pstrb  : m0_pstrb;
    assign spi_pwdata  = r_own ? m1_pwdata : m0_pwdata;

    // Upstream: only the owner sees completion; a watchdog completion
    // returns an error with zero data.
    assign w_err   = spi_pready ? spi_pslverr : 1'b1;
    assign w_rdata = (spi_psel && !w_tmo) ? spi_prdata : '0;

    assign m0_pready  = w_done && !r_own;
    assign m1_pready  = w_done &&  r_own;
    assign m0_pslverr = w_done && !r_own && w_err;
    assign m1_pslverr = w_done &&  r_own && w_err;
    assign m0_prdata  = r_own ? '0 : w_rdata;
    assign m1_prdata  = r_own ? w_rdata : '0;

    assign arb_owner = r_own;
    assign arb_busy  = spi_psel;

endmodule

// File: tb/tb_uv_spi_apb_arb.sv
// Directed bench for uv_spi_apb_arb: main instance HOLD_MAX=4/TMO_CYC=8, second instance HOLD_MAX=1.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_uv_spi_apb_arb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        m0_psel, m0_penable, m0_pwrite;
    logic [2:0]  m0_pprot;
    logic [11:0] m0_paddr;
    logic [3:0]  m0_pstrb;
    logic [31:0] m0_pwdata;
    logic [31:0] m0_prdata;
    logic        m0_pready, m0_pslverr;

    logic        m1_psel, m1_penable, m1_pwrite;
    logic [2:0]  m1_pprot;
    logic [11:0] m1_paddr;
    logic [3:0]  m1_pstrb;
    logic [31:0] m1_pwdata;
    logic [31:0] m1_prdata;
    logic        m1_pready, m1_pslverr;

    logic        spi_psel, spi_penable, spi_pwrite;
    logic [2:0]  spi_pprot;
    logic [11:0] spi_paddr;
    logic [3:0]  spi_pstrb;
    logic [31:0] spi_pwdata;
    logic [31:0] spi_prdata;
    logic        spi_pready, spi_pslverr;
    logic        arb_owner, arb_busy;

    // second instance (strict alternation)
    logic        b_m0_psel, b_m1_psel;
    logic [31:0] b_unused_m0_prdata, b_unused_m1_prdata, b_unused_pwdata;
    logic        b_unused_m0_pready, b_unused_m0_pslverr, b_unused_m1_pready, b_unused_m1_pslverr;
    logic        b_spi_psel, b_spi_penable, b_unused_pwrite, b_unused_busy;
    logic [2:0]  b_unused_pprot;
    logic [11:0] b_unused_paddr;
    logic [3:0]  b_unused_pstrb;
    logic        b_arb_owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uv_spi_apb_arb #(.ALEN(12), .DLEN(32), .MLEN(4), .HOLD_MAX(4), .TMO_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite), .m0_pprot(m0_pprot),
        .m0_paddr(m0_paddr), .m0_pstrb(m0_pstrb), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite), .m1_pprot(m1_pprot),
        .m1_paddr(m1_paddr), .m1_pstrb(m1_pstrb), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .spi_psel(spi_psel), .spi_penable(spi_penable), .spi_pwrite(spi_pwrite), .spi_pprot(spi_pprot),
        .spi_paddr(spi_paddr), .spi_pstrb(spi_pstrb), .spi_pwdata(spi_pwdata), .spi_prdata(spi_prdata),
        .spi_pready(spi_pready), .spi_pslverr(spi_pslverr),
        .arb_owner(arb_owner), .arb_busy(arb_busy)
    );

    uv_spi_apb_arb #(.ALEN(12), .DLEN(32), .MLEN(4), .HOLD_MAX(1), .TMO_CYC(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_psel(b_m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite), .m0_pprot(m0_pprot),
        .m0_paddr(m0_paddr), .m0_pstrb(m0_pstrb), .m0_pwdata(m0_pwdata), .m0_prdata(b_unused_m0_prdata),
        .m0_pready(b_unused_m0_pready), .m0_pslverr(b_unused_m0_pslverr),
        .m1_psel(b_m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite), .m1_pprot(m1_pprot),
        .m1_paddr(m1_paddr), .m1_pstrb(m1_pstrb), .m1_pwdata(m1_pwdata), .m1_prdata(b_unused_m1_prdata),
        .m1_pready(b_unused_m1_pready), .m1_pslverr(b_unused_m1_pslverr),
        .spi_psel(b_spi_psel), .spi_penable(b_spi_penable), .spi_pwrite(b_unused_pwrite),
        .spi_pprot(b_unused_pprot), .spi_paddr(b_unused_paddr), .spi_pstrb(b_unused_pstrb),
        .spi_pwdata(b_unused_pwdata), .spi_prdata(spi_prdata),
        .spi_pready(spi_pready), .spi_pslverr(spi_pslverr),
        .arb_owner(b_arb_owner), .arb_busy(b_unused_busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = 1'b0; m0_pprot = 3'd0;
        m0_paddr = '0; m0_pstrb = '0; m0_pwdata = '0;
        m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0; m1_pprot = 3'd0;
        m1_paddr = '0; m1_pstrb = '0; m1_pwdata = '0;
        spi_prdata = '0; spi_pready = 1'b0; spi_pslverr = 1'b0;
        b_m0_psel = 1'b0; b_m1_psel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (spi_psel !== 1'b0) begin errors++; $display("FAIL rst_psel: got %b expected 0", spi_psel); end
        checks++; if (spi_penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b expected 0", spi_penable); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", arb_busy); end
        checks++; if (arb_owner !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b expected 0", arb_owner); end
        checks++; if ({m0_pready, m1_pready, m0_pslverr, m1_pslverr} !== 4'b0) begin
            errors++; $display("FAIL rst_upstream: got %b expected 0000", {m0_pready, m1_pready, m0_pslverr, m1_pslverr});
        end
        m0_psel = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_write();
        spi_pready = 1'b1; spi_pslverr = 1'b0;
        next_cycle();                             // cycle T
        m0_psel = 1'b1; m0_pwrite = 1'b1; m0_paddr = 12'h008; m0_pwdata = 32'hA5A5_0001;
        m0_pstrb = 4'hF; m0_pprot = 3'b010;
        @(negedge clk);
        checks++; if (spi_psel !== 1'b0) begin errors++; $display("FAIL wr_T_psel: got %b expected 0", spi_psel); end
        next_cycle();                             // T+1 SETUP
        @(negedge clk);
        checks++; if ({spi_psel, spi_penable} !== 2'b10) begin errors++; $display("FAIL wr_setup: got %b expected 10", {spi_psel, spi_penable}); end
        checks++; if ({spi_pwrite, spi_pprot, spi_paddr, spi_pstrb, spi_pwdata} !== {1'b1, 3'b010, 12'h008, 4'hF, 32'hA5A5_0001}) begin
            errors++; $display("FAIL wr_payload: got %h %h %h %h expected 008 F A5A50001 2", spi_paddr, spi_pstrb, spi_pwdata, spi_pprot);
        end
        checks++; if (m0_pready !== 1'b0) begin errors++; $display("FAIL wr_setup_pready: got %b expected 0", m0_pready); end
        next_cycle();                             // T+2 ACCESS
        m0_penable = 1'b1;
        @(negedge clk);
        checks++; if ({spi_penable, m0_pready, m0_pslverr, m1_pready} !== 4'b1100) begin
            errors++; $display("FAIL wr_access: got %b expected 1100", {spi_penable, m0_pready, m0_pslverr, m1_pready});
        end
        next_cycle();                             // T+3 IDLE
        m0_psel = 1'b0; m0_penable = 1'b0;
        @(negedge clk);
        checks++; if ({spi_psel, m0_pready, arb_owner} !== 3'b000) begin
            errors++; $display("FAIL wr_idle: got %b expected 000", {spi_psel, m0_pready, arb_owner});
        end
    endtask

    task automatic test_slverr();
        spi_pready = 1'b1; spi_pslverr = 1'b1; spi_prdata = 32'h0000_1234;
        next_cycle();
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 12'h010;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if ({m0_pready, m0_pslverr} !== 2'b11) begin errors++; $display("FAIL err_resp: got %b expected 11", {m0_pready, m0_pslverr}); end
        checks++; if (m0_prdata !== 32'h0000_1234) begin errors++; $display("FAIL err_rdata: got %h expected 00001234", m0_prdata); end
        checks++; if (m1_prdata !== 32'h0) begin errors++; $display("FAIL err_m1_rdata: got %h expected 0", m1_prdata); end
        next_cycle();
        m0_psel = 1'b0; spi_pslverr = 1'b0;
        next_cycle();
    endtask

    task automatic test_hold();
        bit exp_order [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic got [10];
        int n = 0;
        int k = 0;
        spi_pready = 1'b1;
        next_cycle();
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_pwdata = 32'h1111_0000;
        // port 1 alone for three transfers: it owns the port with hold_cnt=3
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (m1_pready === 1'b1) n++;
            if (n < 3) next_cycle();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL hold_prefill: got %0d completions expected 3", n); end
        next_cycle();                             // IDLE: both now requesting
        m0_psel = 1'b1; m0_pwrite = 1'b1; m0_pwdata = 32'h0000_2222;
        for (int c = 0; c < 100 && k < 10; c++) begin
            @(negedge clk);
            if (spi_psel && !spi_penable) begin
                got[k] = arb_owner;
                k++;
            end
            if (k < 10) next_cycle();
        end
        checks++; if (k != 10) begin errors++; $display("FAIL hold_count: got %0d grants expected 10", k); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== exp_order[i]) begin errors++; $display("FAIL hold_grant%0d: got %b expected %b", i, got[i], exp_order[i]); end
        end
        next_cycle();
        m0_psel = 1'b0; m1_psel = 1'b0;
        repeat (2) next_cycle();
    endtask

    task automatic test_read_wait();
        int early = 0;
        spi_pready = 1'b0; spi_prdata = 32'h0000_0042;
        next_cycle();                             // T
        m1_psel = 1'b1; m1_pwrite = 1'b0; m1_paddr = 12'h020;
        next_cycle();                             // T+1
        @(negedge clk);
        checks++; if ({spi_psel, spi_penable, arb_owner, spi_pwrite} !== 4'b1010) begin
            errors++; $display("FAIL rd_setup: got %b expected 1010", {spi_psel, spi_penable, arb_owner, spi_pwrite});
        end
        m1_penable = 1'b1;
        for (int i = 2; i <= 4; i++) begin        // three wait states
            next_cycle();
            @(negedge clk);
            if (m1_pready !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL rd_wait: got %0d early pready expected 0", early); end
        next_cycle();                             // T+5
        spi_pready = 1'b1;
        @(negedge clk);
        checks++; if ({m1_pready, m1_pslverr} !== 2'b10) begin errors++; $display("FAIL rd_done: got %b expected 10", {m1_pready, m1_pslverr}); end
        checks++; if (m1_prdata !== 32'h0000_0042) begin errors++; $display("FAIL rd_data: got %h expected 00000042", m1_prdata); end
        checks++; if (m0_prdata !== 32'h0) begin errors++; $display("FAIL rd_m0_data: got %h expected 0", m0_prdata); end
        next_cycle();
        m1_psel = 1'b0; m1_penable = 1'b0; spi_pready = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        int early = 0;
        spi_pready = 1'b0; spi_pslverr = 1'b0; spi_prdata = 32'hDEAD_BEEF;
        next_cycle();                             // T
        m0_psel = 1'b1; m0_pwrite = 1'b0;
        next_cycle();                             // T+1 SETUP, port 1 queues
        m1_psel = 1'b1; m1_pwrite = 1'b0;
        @(negedge clk);
        checks++; if (arb_owner !== 1'b0) begin errors++; $display("FAIL tmo_owner0: got %b expected 0", arb_owner); end
        m0_penable = 1'b1;
        for (int i = 2; i <= 8; i++) begin        // ACCESS cycles 1..7
            next_cycle();
            @(negedge clk);
            if (m0_pready !== 1'b0 || spi_penable !== 1'b1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles expected 0", early); end
        next_cycle();                             // T+9: 8th ACCESS cycle
        @(negedge clk);
        checks++; if ({m0_pready, m0_pslverr, m1_pready} !== 3'b110) begin
            errors++; $display("FAIL tmo_fire: got %b expected 110", {m0_pready, m0_pslverr, m1_pready});
        end
        checks++; if (m0_prdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h expected 0", m0_prdata); end
        next_cycle();                             // T+10 IDLE, late pready
        m0_psel = 1'b0; m0_penable = 1'b0; spi_pready = 1'b1;
        @(negedge clk);
        checks++; if ({spi_psel, m0_pready, m1_pready} !== 3'b000) begin
            errors++; $display("FAIL tmo_idle: got %b expected 000", {spi_psel, m0_pready, m1_pready});
        end
        next_cycle();                             // T+11 SETUP for port 1
        @(negedge clk);
        checks++; if ({spi_psel, spi_penable, arb_owner} !== 3'b101) begin
            errors++; $display("FAIL tmo_next_setup: got %b expected 101", {spi_psel, spi_penable, arb_owner});
        end
        next_cycle();                             // T+12 ACCESS
        m1_penable = 1'b1;
        @(negedge clk);
        checks++; if ({m1_pready, m1_pslverr, m0_pready} !== 3'b100) begin
            errors++; $display("FAIL tmo_next_done: got %b expected 100", {m1_pready, m1_pslverr, m0_pready});
        end
        checks++; if (m1_prdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_next_rdata: got %h expected deadbeef", m1_prdata); end
        next_cycle();
        m1_psel = 1'b0; m1_penable = 1'b0; spi_pready = 1'b0;
        next_cycle();
    endtask

    task automatic test_tmo_tie();
        spi_pready = 1'b0; spi_pslverr = 1'b0; spi_prdata = 32'h0000_5A5A;
        next_cycle();                             // T
        m0_psel = 1'b1;
        repeat (8) next_cycle();                  // T+8: 7th ACCESS cycle
        next_cycle();                             // T+9: 8th ACCESS cycle, slave answers now
        spi_pready = 1'b1;
        @(negedge clk);
        checks++; if ({m0_pready, m0_pslverr} !== 2'b10) begin errors++; $display("FAIL tie_resp: got %b expected 10", {m0_pready, m0_pslverr}); end
        checks++; if (m0_prdata !== 32'h0000_5A5A) begin errors++; $display("FAIL tie_rdata: got %h expected 00005a5a", m0_prdata); end
        next_cycle();
        m0_psel = 1'b0; spi_pready = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        spi_pready = 1'b0;
        next_cycle();                             // T
        m0_psel = 1'b1;
        repeat (3) next_cycle();                  // T+3: 2nd ACCESS cycle
        @(negedge clk);
        checks++; if (spi_penable !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", spi_penable); end
        rst_n = 1'b0;
        #1;
        checks++; if ({spi_psel, spi_penable, arb_busy, m0_pready} !== 4'b0000) begin
            errors++; $display("FAIL rmid_async: got %b expected 0000", {spi_psel, spi_penable, arb_busy, m0_pready});
        end
        m0_psel = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();                             // T'
        m0_psel = 1'b1; spi_pready = 1'b1;
        @(negedge clk);
        checks++; if (spi_psel !== 1'b0) begin errors++; $display("FAIL rmid_T: got %b expected 0", spi_psel); end
        next_cycle();
        @(negedge clk);
        checks++; if ({spi_psel, spi_penable, arb_owner} !== 3'b100) begin
            errors++; $display("FAIL rmid_setup: got %b expected 100", {spi_psel, spi_penable, arb_owner});
        end
        next_cycle();
        @(negedge clk);
        checks++; if (m0_pready !== 1'b1) begin errors++; $display("FAIL rmid_done: got %b expected 1", m0_pready); end
        next_cycle();
        m0_psel = 1'b0;
        next_cycle();
    endtask

    task automatic test_alternation();
        bit exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic got [4];
        int k = 0;
        spi_pready = 1'b1;
        next_cycle();
        b_m0_psel = 1'b1; b_m1_psel = 1'b1;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (b_spi_psel && !b_spi_penable) begin
                got[k] = b_arb_owner;
                k++;
            end
            if (k < 4) next_cycle();
        end
        checks++; if (k != 4) begin errors++; $display("FAIL alt_count: got %0d grants expected 4", k); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_order[i]) begin errors++; $display("FAIL alt_grant%0d: got %b expected %b", i, got[i], exp_order[i]); end
        end
        next_cycle();
        b_m0_psel = 1'b0; b_m1_psel = 1'b0; spi_pready = 1'b0;
        repeat (2) next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_slverr();
        test_hold();
        test_read_wait();
        test_timeout();
        test_tmo_tie();
        test_reset_mid();
        test_alternation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
